linescanner_capture_unit: RTL and testbench
===========================================

Name: linescanner_capture_unit

Overview:
Front-end stage that drives a CCD/CMOS line-scan sensor (clock + start pulse) and samples its external 8-bit ADC output.
Emits one registered byte per pixel, with a single-cycle strobe, as `pixel_data`/`pixel_captured`.
Sits directly upstream of linescanner2stream_convertor, which packs these bytes into AXI-Stream.
One clock domain; sensor clock is derived by division, not a separate domain.

Parameters:
PIXELS_PER_LINE, 1024, pixels read out per line (>=2).
CLK_DIV, 4, axi_aclk cycles per half period of sensor_clk (>=2).
INTEGRATION_GAP, 16, sensor_clk periods idled between lines (>=1).

Ports:
axi_aclk  in  1  system clock, all logic on rising edge.
axi_aresetn  in  1  reset, asynchronous, active-low.
enable  in  1  level; high = capture lines continuously.
adc_data  in  8  sensor ADC output, valid at sensor_clk falling edge.
sensor_clk  out  1  sensor pixel clock.
sensor_si  out  1  sensor start-of-integration/readout pulse.
pixel_data  out  8  captured pixel value.
pixel_captured  out  1  one-cycle strobe, pixel_data valid.
line_done  out  1  one-cycle strobe with the last pixel of a line.
busy  out  1  high whenever FSM not IDLE.

Behaviour:
- Reset (async, immediate): all outputs 0, FSM=IDLE, all counters 0.
- Divider: div_cnt 0..CLK_DIV-1 runs only outside IDLE.
  - At div_cnt==CLK_DIV-1, sensor_clk toggles.
  - Internal rise_evt/fall_evt is a one-cycle strobe on each toggle.
  - In IDLE, sensor_clk is held 0 and div_cnt is 0.
- FSM states: IDLE, START, READ, GAP.
- IDLE -> START when enable=1.
- START:
  - Set sensor_si=1 at the first fall_evt.
  - Clear it at the next fall_evt, so SI spans exactly one rising edge.
  - On clearing SI, go to READ with pix_cnt=0.
- READ:
  - At each fall_evt, register adc_data into pixel_data.
  - Assert pixel_captured in the next axi_aclk cycle for exactly 1 cycle.
  - pix_cnt increments per capture.
  - On capture of pixel PIXELS_PER_LINE-1, assert line_done in the same cycle as pixel_captured, then go to GAP.
- GAP:
  - Count INTEGRATION_GAP fall_evts, keeping sensor_clk running.
  - Then go to START if enable=1, else IDLE.
- Capture spacing: consecutive pixel_captured pulses are exactly 2*CLK_DIV cycles apart.
- pixel_data holds its value between strobes.
- enable deasserted mid-line: current line always completes (full readout required by sensor), followed by GAP, then IDLE.
- enable re-asserted during GAP: next line starts normally.
- Counter widths: pix_cnt $clog2(PIXELS_PER_LINE); gap counter $clog2(INTEGRATION_GAP+1); no wrap beyond terminal values.
- Reset mid-line: abort immediately. After release, a new line begins from START (fresh SI); there is no partial continuation.
- busy = (state != IDLE).

Optional Feature:
LINESCANNER_TEST_PATTERN_EN
- Defined: adds input port test_mode (1 bit). When test_mode=1, pixel_data = pix_cnt[7:0] instead of adc_data; timing is identical.
- Undefined: no test_mode port; pixel_data always comes from adc_data.

Decomposition:
- Package linescanner_pkg: FSM state encoding constants (IDLE=0, START=1, READ=2, GAP=3), pixel width constant (8), width helper for counters.
- Sub-module linescanner_clock_divider: div_cnt, sensor_clk and rise_evt/fall_evt generation, with a run input. FSM and capture logic stay in the top.

Test Plan:
Bench configuration: PIXELS_PER_LINE=8, CLK_DIV=2, INTEGRATION_GAP=3; the bench models the ADC as adc_data = index of the last sensor_clk rise after SI.
1. Hold reset 5 cycles, enable=1 -> all outputs 0, sensor_clk static 0 during reset.
2. Release reset, enable=1 ->
   - sensor_si high for exactly 4 cycles, spanning one sensor_clk rise;
   - then 8 pixel_captured pulses 4 cycles apart, pixel_data 0..7;
   - line_done coincides with the pulse carrying 7.
3. Keep enable=1 -> after 3 gap periods (12 cycles), a second SI; second line again yields 0..7; busy stays 1 throughout.
4. Drop enable after pixel 3 of a line -> pixels 4..7 still captured, line_done fires, gap elapses, then IDLE: busy=0, sensor_clk=0, no further SI.
5. Assert reset at pixel 5 -> outputs 0 immediately; release with enable=1 -> new SI, capture restarts at pixel 0.
6. With LINESCANNER_TEST_PATTERN_EN, test_mode=1, adc_data=8'hAA -> pixel_data 0..7, not AA; test_mode=0 -> AA on every strobe.

Source files
------------

// File: rtl/linescanner_pkg.sv
// Shared constants for the line-scan capture slice: FSM encoding, pixel width
// and a counter-width helper.
package linescanner_pkg;

  localparam int PIXEL_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Bits needed to hold the values 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/linescanner_capture_unit_if.sv
// Sensor-side and pixel-side signals of the line-scan capture unit.
// The master is the capture unit; the slave is the sensor/ADC plus the downstream packer.
interface linescanner_capture_unit_if;
  import linescanner_pkg::*;

  logic               sensor_clk;
  logic               sensor_si;
  logic [PIXEL_W-1:0] adc_data;
  logic [PIXEL_W-1:0] pixel_data;
  logic               pixel_captured;
  logic               line_done;

  // pixel_captured is a valid-only strobe with no ready: the consumer must take
  // pixel_data in the single cycle it is high; line_done only ever rides along with it.
  modport master (
    output sensor_clk, sensor_si, pixel_data, pixel_captured, line_done,
    input  adc_data
  );

  modport slave (
    input  sensor_clk, sensor_si, pixel_data, pixel_captured, line_done,
    output adc_data
  );

endinterface

// File: rtl/linescanner_clock_divider.sv
// Sensor clock divider: toggles sensor_clk every CLK_DIV cycles while run is high
// and flags each toggle with a one-cycle rise_evt/fall_evt registered alongside it.
module linescanner_clock_divider
  import linescanner_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sensor_clk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int              DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sensor_clk <= 1'b0;
      rise_evt   <= 1'b0;
      fall_evt   <= 1'b0;
    end else if (!run) begin
      div_cnt    <= '0;
      sensor_clk <= 1'b0;
      rise_evt   <= 1'b0;
      fall_evt   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      sensor_clk <= ~sensor_clk;
      rise_evt   <= ~sensor_clk;
      fall_evt   <= sensor_clk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end
  end

endmodule

// File: rtl/linescanner_capture_unit.sv
// Line-scan sensor front end: generates sensor_clk/sensor_si and registers one ADC
// byte per pixel. Optional LINESCANNER_TEST_PATTERN_EN adds test_mode (pixel index as data).
module linescanner_capture_unit
  import linescanner_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 1024,
  parameter int CLK_DIV         = 4,
  parameter int INTEGRATION_GAP = 16
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic                        enable,
`ifdef LINESCANNER_TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  linescanner_capture_unit_if.master  bus,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int             PCW      = cnt_width(PIXELS_PER_LINE);
  localparam int             GCW      = cnt_width(INTEGRATION_GAP + 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXELS_PER_LINE - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(INTEGRATION_GAP - 1);

  logic [1:0]         state;
  logic [PCW-1:0]     pix_cnt;
  logic [GCW-1:0]     gap_cnt;
  logic               si_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               captured_q;
  logic               line_done_q;
  logic               rise_evt;
  logic               fall_evt;
  logic [PIXEL_W-1:0] capture_value;
  logic [PIXEL_W+PCW-1:0] pix_ext;

  linescanner_clock_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .run        (state != ST_IDLE),
    .sensor_clk (bus.sensor_clk),
    .rise_evt   (rise_evt),
    .fall_evt   (fall_evt)
  );

  assign pix_ext = {{PIXEL_W{1'b0}}, pix_cnt};

`ifdef LINESCANNER_TEST_PATTERN_EN
  assign capture_value = test_mode ? pix_ext[PIXEL_W-1:0] : bus.adc_data;
`else
  assign capture_value = bus.adc_data;
`endif

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      gap_cnt     <= '0;
      si_q        <= 1'b0;
      pixel_q     <= '0;
      captured_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      captured_q  <= 1'b0;
      line_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_START;
        end
        ST_START: begin
          // SI rises on one sensor_clk fall and drops on the next, bracketing one rise.
          if (fall_evt) begin
            if (!si_q) begin
              si_q <= 1'b1;
            end else begin
              si_q    <= 1'b0;
              pix_cnt <= '0;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (fall_evt) begin
            pixel_q    <= capture_value;
            captured_q <= 1'b1;
            if (pix_cnt == PIX_LAST) begin
              line_done_q <= 1'b1;
              gap_cnt     <= '0;
              state       <= ST_GAP;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          // The fall that closes the gap doubles as START's first fall, so back-to-back
          // lines are separated by exactly INTEGRATION_GAP sensor periods.
          if (fall_evt) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              if (enable) begin
                si_q  <= 1'b1;
                state <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sensor_si      = si_q;
  assign bus.pixel_data     = pixel_q;
  assign bus.pixel_captured = captured_q;
  assign bus.line_done      = line_done_q;
  assign busy               = (state != ST_IDLE);
  assign state_dbg          = state;

endmodule

// File: tb/tb_linescanner_capture_unit.sv
// Directed bench for linescanner_capture_unit (8 pixels, divide-by-2, 3-period gap);
// covers reset, continuous lines, enable drop, mid-line reset and, with LINESCANNER_TEST_PATTERN_EN, test_mode.
module tb_linescanner_capture_unit;

  localparam int PPL = 8;
  localparam int DIV = 2;
  localparam int GAP = 3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;
`ifdef LINESCANNER_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  linescanner_capture_unit_if bus ();

  linescanner_capture_unit #(
    .PIXELS_PER_LINE (PPL),
    .CLK_DIV         (DIV),
    .INTEGRATION_GAP (GAP)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .enable      (enable),
`ifdef LINESCANNER_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .bus         (bus),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: value = index of the latest sensor_clk rise since SI fell
  int         rise_idx     = 0;
  logic       prev_si      = 1'b0;
  logic       prev_sclk    = 1'b0;
  logic       adc_model_en = 1'b1;
  logic [7:0] adc_fixed    = 8'hAA;
  always @(negedge clk) begin
    if (prev_si && !bus.sensor_si) rise_idx = -1;
    else if (!prev_sclk && bus.sensor_clk) rise_idx = rise_idx + 1;
    prev_si   = bus.sensor_si;
    prev_sclk = bus.sensor_clk;
    bus.adc_data = adc_model_en ? 8'(rise_idx) : adc_fixed;
  end

  logic watch_busy    = 1'b0;
  logic busy_dropped  = 1'b0;
  always @(negedge clk) if (watch_busy && !busy) busy_dropped = 1'b1;

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;
  int last_cap_cyc = 0;
  int si_rise_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_si(input string tag);
    int   n = 0;
    int   width = 0;
    int   rises = 0;
    logic ps;
    while (bus.sensor_si !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " si_seen"}, 32'(bus.sensor_si), 32'd1);
    si_rise_cyc = cyc;
    ps = bus.sensor_clk;
    while (bus.sensor_si === 1'b1 && width < 100) begin
      @(negedge clk);
      width++;
      if (!ps && bus.sensor_clk) rises++;
      ps = bus.sensor_clk;
    end
    check({tag, " si_width"}, 32'(width), 32'(2 * DIV));
    check({tag, " si_rises"}, 32'(rises), 32'd1);
  endtask

  task automatic wait_capture(input string tag, input int exp_pix, input logic exp_ld,
                              input logic chk_space, input logic do_hold);
    int         n = 0;
    logic [7:0] held;
    @(negedge clk);
    while (bus.pixel_captured !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " strobe"}, 32'(bus.pixel_captured), 32'd1);
    check({tag, " data"}, 32'(bus.pixel_data), 32'(exp_pix));
    check({tag, " line_done"}, 32'(bus.line_done), 32'(exp_ld));
    if (chk_space) check({tag, " spacing"}, 32'(cyc - last_cap_cyc), 32'(2 * DIV));
    last_cap_cyc = cyc;
    if (do_hold) begin
      held = bus.pixel_data;
      @(negedge clk);
      check({tag, " pulse_end"}, 32'(bus.pixel_captured), 32'd0);
      check({tag, " hold"}, 32'(bus.pixel_data), 32'(held));
    end
  endtask

  // fixed_val < 0 selects the pixel index as the expected value
  task automatic run_line(input string tag, input int first, input int last,
                          input int fixed_val, input logic space_first);
    for (int i = first; i <= last; i++)
      wait_capture($sformatf("%s p%0d", tag, i), (fixed_val < 0) ? i : fixed_val,
                   (i == PPL - 1), (i > first) || space_first, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sclk"}, 32'(bus.sensor_clk), 32'd0);
    check({tag, " si"}, 32'(bus.sensor_si), 32'd0);
    check({tag, " data"}, 32'(bus.pixel_data), 32'd0);
    check({tag, " strobe"}, 32'(bus.pixel_captured), 32'd0);
    check({tag, " line_done"}, 32'(bus.line_done), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    int n;
    int si_hits;
    int sclk_hits;

    // 1: reset held with enable high
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst sclk c%0d", i), 32'(bus.sensor_clk), 32'd0);
    end
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 2: first line
    wait_si("L1");
    run_line("L1", 0, PPL - 1, -1, 1'b0);
    check("L1 busy", 32'(busy), 32'd1);

    // 3: continuous capture, gap of GAP sensor periods
    watch_busy = 1'b1;
    wait_si("L2");
    check("L2 gap_len", 32'(si_rise_cyc - last_cap_cyc), 32'(GAP * 2 * DIV));
    run_line("L2", 0, PPL - 1, -1, 1'b0);
    watch_busy = 1'b0;
    check("L2 busy_held", 32'(busy_dropped), 32'd0);

    // 4: enable dropped after pixel 3; line completes, gap, then idle
    wait_si("L3");
    run_line("L3", 0, 3, -1, 1'b0);
    enable = 1'b0;
    run_line("L3", 4, PPL - 1, -1, 1'b1);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("L3 idle_delay", 32'(cyc - last_cap_cyc), 32'(GAP * 2 * DIV));
    check("L3 idle_sclk", 32'(bus.sensor_clk), 32'd0);
    check("L3 idle_state", 32'(state_dbg), 32'd0);
    si_hits   = 0;
    sclk_hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sensor_si) si_hits++;
      if (bus.sensor_clk) sclk_hits++;
    end
    check("idle si_quiet", 32'(si_hits), 32'd0);
    check("idle sclk_quiet", 32'(sclk_hits), 32'd0);
    check("idle busy", 32'(busy), 32'd0);

    // 5: reset asserted on pixel 5, then a fresh line from SI
    enable = 1'b1;
    wait_si("L4");
    run_line("L4", 0, 4, -1, 1'b0);
    wait_capture("L4 p5", 5, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_si("L5");
    run_line("L5", 0, PPL - 1, -1, 1'b0);

`ifdef LINESCANNER_TEST_PATTERN_EN
    // 6: test pattern overrides the ADC, then ADC path again
    test_mode    = 1'b1;
    adc_model_en = 1'b0;
    wait_si("L6");
    run_line("L6", 0, PPL - 1, -1, 1'b0);
    test_mode = 1'b0;
    wait_si("L7");
    run_line("L7", 0, PPL - 1, 32'hAA, 1'b0);
`endif

    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("final busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
